// File: rtl/pc_sequencer_if.sv
// Counter/instruction-bus bundle between the fetch/decode sequencer and the
// 161-style program counter plus instruction memory.
// Signalling: there is no valid/ready handshake on this bus. The sequencer
// drives the counter control pins every cycle and the counter acts on them
// at the next rising edge. Q/RCO and OP/OPR are plain readback levels that
// must be stable whenever the sequencer samples them.
interface pc_sequencer_if;
   logic       PC_CLRn;
   logic       PC_LDn;
   logic       PC_ENP;
   logic       PC_ENT;
   logic [3:0] PC_D;
   logic [3:0] PC_Q;
   logic       PC_RCO;
   logic       IR_LDn;
   logic [3:0] OP;
   logic [3:0] OPR;

   modport master (
      output PC_CLRn, PC_LDn, PC_ENP, PC_ENT, PC_D, IR_LDn,
      input  PC_Q, PC_RCO, OP, OPR
   );

   modport slave (
      input  PC_CLRn, PC_LDn, PC_ENP, PC_ENT, PC_D, IR_LDn,
      output PC_Q, PC_RCO, OP, OPR
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer controlling a 4-bit 161-style program counter and
// the instruction-register load strobe. Decides increment / load / hold /
// clear each instruction and enforces the 0..14 program-space wrap rule.
module pc_sequencer (
   input  logic       CLK,
   input  logic       CLRn,
   input  logic       START,
   input  logic       STOP,
   input  logic       ZF,
   input  logic       CF,
   pc_sequencer_if.master pc,
   output logic       HALTED,
   output logic       WRAP,
   output logic [7:0] ICOUNT,
   output logic [2:0] DBG_STATE
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_JC  = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state_q, state_d;
   logic       pc_clrn_q, pc_clrn_d;
   logic       wrap_q, wrap_d;
   logic [7:0] icount_q, icount_d;

   logic       ld_n;
   logic       cnt_en;
   logic [3:0] pc_d;
   logic       ir_ld_n;
   logic       take_jump;
   logic       wrap_hit;

   // An increment would leave program space: 14 with carry readback, or 15.
   assign wrap_hit = ((pc.PC_Q == 4'd14) && pc.PC_RCO) || (pc.PC_Q == 4'd15);

   // State, registered counter clear, sticky wrap flag and retire counter.
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         state_q   <= S_IDLE;
         pc_clrn_q <= 1'b0;
         wrap_q    <= 1'b0;
         icount_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         pc_clrn_q <= pc_clrn_d;
         wrap_q    <= wrap_d;
         icount_q  <= icount_d;
      end
   end

   // Next state and counter controls; STOP overrides every decision last.
   always_comb begin
      state_d   = state_q;
      ld_n      = 1'b1;
      cnt_en    = 1'b0;
      pc_d      = 4'd0;
      ir_ld_n   = 1'b1;
      wrap_d    = wrap_q;
      icount_d  = icount_q;
      take_jump = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_ld_n = 1'b0;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (pc.OP)
               OP_JMP:  take_jump = 1'b1;
               OP_JZ:   take_jump = ZF;
               OP_JC:   take_jump = CF;
               default: take_jump = 1'b0;
            endcase

            if (take_jump) begin
               ld_n = 1'b0;
               pc_d = pc.OPR;
            end else if (wrap_hit) begin
               // Wrapping increment becomes an explicit load of 0.
               ld_n   = 1'b0;
               pc_d   = 4'd0;
               wrap_d = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end

            if (icount_q != 8'hFF) icount_d = icount_q + 8'd1;

            case (pc.OP)
               OP_JMP, OP_JZ, OP_JC, OP_NOP: state_d = S_FETCH;
               OP_HLT:                       state_d = S_HALT;
               default:                      state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            if (START) state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (STOP) begin
         state_d  = S_IDLE;
         ld_n     = 1'b1;
         cnt_en   = 1'b0;
         pc_d     = 4'd0;
         wrap_d   = wrap_q;
         icount_d = icount_q;
      end
   end

   // Counter clear releases on the START edge and re-asserts on STOP.
   assign pc_clrn_d = !STOP && ((state_q != S_IDLE) || START);

   assign pc.PC_CLRn = pc_clrn_q;
   assign pc.PC_LDn  = ld_n;
   assign pc.PC_ENP  = cnt_en;
   assign pc.PC_ENT  = cnt_en;
   assign pc.PC_D    = pc_d;
   assign pc.IR_LDn  = ir_ld_n;

   assign HALTED    = (state_q == S_HALT);
   assign WRAP      = wrap_q;
   assign ICOUNT    = icount_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small 161-style counter model and
// a 16-entry instruction memory addressed by the counter readback.
module tb_pc_sequencer;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, zf, cf;
   logic       halted, wrap;
   logic [7:0] icount;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .CLK       (clk),
      .CLRn      (rst_n),
      .START     (start),
      .STOP      (stop),
      .ZF        (zf),
      .CF        (cf),
      .pc        (bus),
      .HALTED    (halted),
      .WRAP      (wrap),
      .ICOUNT    (icount),
      .DBG_STATE (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Counter model with optional readback override for corner cases.
   logic [3:0] cnt_q = 4'd0;
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_q = 4'd0;
   logic       ovr_rco = 1'b0;
   logic [7:0] imem [16];

   always @(posedge clk) begin
      if (!bus.PC_CLRn)                 cnt_q <= 4'd0;
      else if (!bus.PC_LDn)             cnt_q <= bus.PC_D;
      else if (bus.PC_ENP && bus.PC_ENT) cnt_q <= cnt_q + 4'd1;
   end

   assign bus.PC_Q   = ovr_en ? ovr_q : cnt_q;
   assign bus.PC_RCO = ovr_en ? ovr_rco : ((cnt_q == 4'd15) && bus.PC_ENT);
   assign bus.OP     = imem[bus.PC_Q][7:4];
   assign bus.OPR    = imem[bus.PC_Q][3:0];

   // Counter-control invariants checked every cycle outside reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ((bus.PC_ENP !== bus.PC_ENT) || (bus.PC_LDn === 1'b0 && bus.PC_ENP === 1'b1)) begin
            errors++;
            $display("FAIL enable_invariant: ENP=%b ENT=%b LDn=%b", bus.PC_ENP, bus.PC_ENT, bus.PC_LDn);
         end
      end
   end

   // Driver tasks
   task automatic load_nops();
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      zf     = 1'b0;
      cf     = 1'b0;
      ovr_en = 1'b0;
      load_nops();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse START so the next negedge lands in the first FETCH.
   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [21:0] act;
      logic [21:0] exp_v;
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      zf    = 1'b0;
      cf    = 1'b0;
      load_nops();
      @(negedge clk);
      act   = {bus.PC_CLRn, bus.PC_LDn, bus.PC_ENP, bus.PC_ENT, bus.PC_D, bus.IR_LDn,
               halted, wrap, icount, dbg_state};
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, S_IDLE};
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", act, exp_v);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE || bus.PC_CLRn !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: state=%0d clrn=%b expected 0/0", dbg_state, bus.PC_CLRn);
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [21:0] act;
      logic [21:0] exp_v;
      do_reset();
      imem[0] = 8'h30;
      kick();                 // FETCH
      @(negedge clk);         // DECODE
      @(negedge clk);         // EXEC
      checks++;
      if (dbg_state !== S_EXEC || icount !== 8'd1) begin
         errors++;
         $display("FAIL mid_exec_setup: state=%0d icount=%0d expected 3/1", dbg_state, icount);
      end
      #2;
      rst_n = 1'b0;
      #1;
      act   = {bus.PC_CLRn, bus.PC_LDn, bus.PC_ENP, bus.PC_ENT, bus.PC_D, bus.IR_LDn,
               halted, wrap, icount, dbg_state};
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, S_IDLE};
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", act, exp_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (dbg_state !== S_IDLE || bus.PC_CLRn !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: state=%0d clrn=%b expected 0/0", dbg_state, bus.PC_CLRn);
         end
      end
   endtask

   task automatic test_program();
      do_reset();
      imem[0] = 8'h00;        // NOP
      imem[1] = 8'h30;        // ALU op
      imem[2] = 8'hA2;        // JMP 2
      kick();
      checks++;
      if (dbg_state !== S_FETCH || bus.IR_LDn !== 1'b0 || bus.PC_Q !== 4'd0 || bus.PC_CLRn !== 1'b1) begin
         errors++;
         $display("FAIL first_fetch: state=%0d irldn=%b pc=%0d clrn=%b expected 1/0/0/1",
                  dbg_state, bus.IR_LDn, bus.PC_Q, bus.PC_CLRn);
      end
      @(negedge clk);         // DECODE NOP
      checks++;
      if (bus.PC_ENP !== 1'b1 || bus.PC_LDn !== 1'b1 || bus.IR_LDn !== 1'b1) begin
         errors++;
         $display("FAIL nop_increment: enp=%b ldn=%b irldn=%b expected 1/1/1", bus.PC_ENP, bus.PC_LDn, bus.IR_LDn);
      end
      @(negedge clk);         // FETCH at 1
      checks++;
      if (dbg_state !== S_FETCH || bus.PC_Q !== 4'd1 || icount !== 8'd1) begin
         errors++;
         $display("FAIL fetch_pc1: state=%0d pc=%0d icount=%0d expected 1/1/1", dbg_state, bus.PC_Q, icount);
      end
      @(negedge clk);         // DECODE ALU op
      @(negedge clk);         // EXEC
      checks++;
      if (dbg_state !== S_EXEC || bus.PC_Q !== 4'd2 || bus.PC_ENP !== 1'b0 || bus.PC_LDn !== 1'b1) begin
         errors++;
         $display("FAIL exec_hold: state=%0d pc=%0d enp=%b ldn=%b expected 3/2/0/1",
                  dbg_state, bus.PC_Q, bus.PC_ENP, bus.PC_LDn);
      end
      @(negedge clk);         // FETCH at 2
      @(negedge clk);         // DECODE JMP 2
      checks++;
      if (bus.PC_LDn !== 1'b0 || bus.PC_D !== 4'd2 || bus.PC_ENP !== 1'b0) begin
         errors++;
         $display("FAIL jmp_load: ldn=%b d=%0d enp=%b expected 0/2/0", bus.PC_LDn, bus.PC_D, bus.PC_ENP);
      end
      @(negedge clk);         // FETCH at 2 again
      checks++;
      if (dbg_state !== S_FETCH || bus.PC_Q !== 4'd2 || icount !== 8'd3) begin
         errors++;
         $display("FAIL jmp_loop: state=%0d pc=%0d icount=%0d expected 1/2/3", dbg_state, bus.PC_Q, icount);
      end
   endtask

   task automatic test_cond_jumps();
      do_reset();
      imem[0] = 8'hA4;        // JMP 4
      imem[4] = 8'hB9;        // JZ 9
      imem[5] = 8'hA4;        // JMP 4
      imem[9] = 8'hCC;        // JC 12
      kick();                 // FETCH 0
      @(negedge clk);         // DECODE 0
      @(negedge clk);         // FETCH 4
      @(negedge clk);         // DECODE JZ, ZF=0
      checks++;
      if (bus.PC_ENP !== 1'b1 || bus.PC_LDn !== 1'b1) begin
         errors++;
         $display("FAIL jz_not_taken: enp=%b ldn=%b expected 1/1", bus.PC_ENP, bus.PC_LDn);
      end
      @(negedge clk);         // FETCH 5
      checks++;
      if (bus.PC_Q !== 4'd5) begin
         errors++;
         $display("FAIL jz_fallthrough_pc: got %0d expected 5", bus.PC_Q);
      end
      @(negedge clk);         // DECODE JMP 4
      @(negedge clk);         // FETCH 4
      zf = 1'b1;
      @(negedge clk);         // DECODE JZ, ZF=1
      checks++;
      if (bus.PC_LDn !== 1'b0 || bus.PC_D !== 4'd9 || bus.PC_ENP !== 1'b0) begin
         errors++;
         $display("FAIL jz_taken: ldn=%b d=%0d enp=%b expected 0/9/0", bus.PC_LDn, bus.PC_D, bus.PC_ENP);
      end
      @(negedge clk);         // FETCH 9
      checks++;
      if (bus.PC_Q !== 4'd9) begin
         errors++;
         $display("FAIL jz_target_pc: got %0d expected 9", bus.PC_Q);
      end
      cf = 1'b1;
      @(negedge clk);         // DECODE JC, CF=1
      checks++;
      if (bus.PC_LDn !== 1'b0 || bus.PC_D !== 4'd12) begin
         errors++;
         $display("FAIL jc_taken: ldn=%b d=%0d expected 0/12", bus.PC_LDn, bus.PC_D);
      end
      @(negedge clk);         // FETCH 12
      checks++;
      if (bus.PC_Q !== 4'd12 || icount !== 8'd5) begin
         errors++;
         $display("FAIL jc_target: pc=%0d icount=%0d expected 12/5", bus.PC_Q, icount);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      ovr_en  = 1'b1;
      ovr_q   = 4'd14;
      ovr_rco = 1'b1;
      kick();                 // FETCH at 14
      @(negedge clk);         // DECODE NOP at 14
      checks++;
      if (bus.PC_LDn !== 1'b0 || bus.PC_D !== 4'd0 || bus.PC_ENP !== 1'b0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap14_load: ldn=%b d=%0d enp=%b wrap=%b expected 0/0/0/0",
                  bus.PC_LDn, bus.PC_D, bus.PC_ENP, wrap);
      end
      @(negedge clk);
      checks++;
      if (wrap !== 1'b1 || dbg_state !== S_FETCH) begin
         errors++;
         $display("FAIL wrap14_flag: wrap=%b state=%0d expected 1/1", wrap, dbg_state);
      end
      stop = 1'b1;
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE || bus.PC_CLRn !== 1'b0 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_after_stop: state=%0d clrn=%b wrap=%b expected 0/0/1", dbg_state, bus.PC_CLRn, wrap);
      end
      stop   = 1'b0;
      ovr_en = 1'b0;

      // Jump to 15 is legal; the increment from 15 wraps.
      do_reset();
      checks++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_cleared_by_reset: got %b expected 0", wrap);
      end
      imem[0] = 8'hAF;
      kick();                 // FETCH 0
      @(negedge clk);         // DECODE JMP 15
      @(negedge clk);         // FETCH 15
      checks++;
      if (bus.PC_Q !== 4'd15 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL jump_to_15: pc=%0d wrap=%b expected 15/0", bus.PC_Q, wrap);
      end
      @(negedge clk);         // DECODE NOP at 15
      checks++;
      if (bus.PC_LDn !== 1'b0 || bus.PC_D !== 4'd0 || bus.PC_ENP !== 1'b0) begin
         errors++;
         $display("FAIL wrap15_load: ldn=%b d=%0d enp=%b expected 0/0/0", bus.PC_LDn, bus.PC_D, bus.PC_ENP);
      end
      @(negedge clk);
      checks++;
      if (bus.PC_Q !== 4'd0 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap15_result: pc=%0d wrap=%b expected 0/1", bus.PC_Q, wrap);
      end
   endtask

   task automatic test_halt();
      do_reset();
      imem[0] = 8'hA6;
      imem[6] = 8'hF0;
      kick();                 // FETCH 0
      @(negedge clk);         // DECODE JMP 6
      @(negedge clk);         // FETCH 6
      @(negedge clk);         // DECODE HLT
      checks++;
      if (bus.PC_ENP !== 1'b1 || bus.PC_LDn !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL hlt_increment: enp=%b ldn=%b halted=%b expected 1/1/0", bus.PC_ENP, bus.PC_LDn, halted);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || bus.PC_Q !== 4'd7 || bus.PC_ENP !== 1'b0 || bus.PC_LDn !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold[%0d]: halted=%b pc=%0d enp=%b ldn=%b expected 1/7/0/1",
                     i, halted, bus.PC_Q, bus.PC_ENP, bus.PC_LDn);
         end
      end
      kick();
      checks++;
      if (dbg_state !== S_FETCH || halted !== 1'b0 || bus.PC_Q !== 4'd7 || bus.IR_LDn !== 1'b0) begin
         errors++;
         $display("FAIL resume: state=%0d halted=%b pc=%0d irldn=%b expected 1/0/7/0",
                  dbg_state, halted, bus.PC_Q, bus.IR_LDn);
      end
   endtask

   task automatic test_stop_in_decode();
      do_reset();
      imem[0] = 8'hAC;
      kick();                 // FETCH 0
      @(negedge clk);         // DECODE JMP 12
      stop  = 1'b1;
      start = 1'b1;
      #1;
      checks++;
      if (dbg_state !== S_DECODE || bus.PC_LDn !== 1'b1 || bus.PC_ENP !== 1'b0) begin
         errors++;
         $display("FAIL stop_suppresses_load: state=%0d ldn=%b enp=%b expected 2/1/0",
                  dbg_state, bus.PC_LDn, bus.PC_ENP);
      end
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE || bus.PC_CLRn !== 1'b0 || icount !== 8'd0) begin
         errors++;
         $display("FAIL stop_to_idle: state=%0d clrn=%b icount=%0d expected 0/0/0", dbg_state, bus.PC_CLRn, icount);
      end
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE || bus.PC_Q !== 4'd0) begin
         errors++;
         $display("FAIL stop_beats_start: state=%0d pc=%0d expected 0/0", dbg_state, bus.PC_Q);
      end
      stop  = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_icount_saturate();
      do_reset();
      kick();                 // FETCH 0, ICOUNT=0
      repeat (400) @(negedge clk);
      checks++;
      if (icount !== 8'd200 || dbg_state !== S_FETCH) begin
         errors++;
         $display("FAIL icount_200: icount=%0d state=%0d expected 200/1", icount, dbg_state);
      end
      repeat (200) @(negedge clk);
      checks++;
      if (icount !== 8'd255 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL icount_sat: icount=%0d wrap=%b expected 255/1", icount, wrap);
      end
      stop = 1'b1;
      @(negedge clk);
      checks++;
      if (icount !== 8'd255 || dbg_state !== S_IDLE) begin
         errors++;
         $display("FAIL icount_kept: icount=%0d state=%0d expected 255/0", icount, dbg_state);
      end
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_exec();
      test_program();
      test_cond_jumps();
      test_wrap();
      test_halt();
      test_stop_in_decode();
      test_icount_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
